bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial stage feeding the run-length pulse detector's single-bit input stream. Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per clock. Inserts a programmable number of forced-zero gap bits between words, so that runs of ones never merge across word boundaries. A one-word holding register lets the producer hand over the next word while the current one is still shifting, which sustains continuous streaming.

## Interface
- WIDTH, 8: word width in bits; legal range WIDTH >= 2.
- GAP, 1: number of forced-zero idle cycles after each word; legal range GAP >= 0.
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  word to serialize.
- data_valid  in  1  producer has a word on data_in.
- data_ready  out  1  holding register empty; a word is accepted when data_valid && data_ready at a rising edge.
- serial_bit  out  1  serial data; 0 whenever serial_active is 0.
- serial_active  out  1  serial_bit carries a word bit this cycle.
- word_start  out  1  one-cycle pulse coinciding with the first bit of each word.

## Operation
- Holding register
  - Storage: hold[WIDTH-1:0] plus hold_full.
  - data_ready = !hold_full (combinational from a register only; no dependence on data_valid).
  - An accept and an unload can never occur at the same edge.
- State machine
  - States: IDLE, SHIFT, GAP.
  - IDLE: if hold_full, load the shifter from hold, clear hold_full, set bit_cnt=0 and go to SHIFT; otherwise stay in IDLE.
  - SHIFT: present one bit per cycle and increment bit_cnt.
  - SHIFT, at bit_cnt==WIDTH-1:
    - GAP>0: go to GAP with gap_cnt=0.
    - GAP==0 and hold_full: reload the shifter and stay in SHIFT (back-to-back words).
    - GAP==0 and hold empty: go to IDLE.
  - GAP: serial_bit=0, serial_active=0; increment gap_cnt.
  - GAP, at gap_cnt==GAP-1: reload if hold_full (go to SHIFT), otherwise go to IDLE.
- Bit ordering
  - MSB_FIRST=1: present shift[WIDTH-1], shift left, zero-fill.
  - MSB_FIRST=0: present shift[0], shift right, zero-fill.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; gap_cnt is max(1,$clog2(GAP+1)) bits. Both counters compare for equality only and never wrap past their terminal value.
- Output registering
  - serial_bit, serial_active and word_start are registered outputs.
  - word_start=1 exactly in the cycle that carries the first bit of a word.
- Reset (reset low, at any time, including mid-word)
  - Asynchronously clears: state=IDLE, hold_full=0, shifter, counters, serial_bit=0, serial_active=0, word_start=0.
  - data_ready reads 1 while reset is low.
  - A partially shifted word is discarded; nothing resumes after reset.

## Timing
- Latency: a word accepted at edge t in IDLE is loaded into the shifter at edge t+1. Its first bit drives serial_bit after edge t+1.
- Word duration: exactly WIDTH cycles with serial_active=1.
- Word spacing: GAP zero cycles between consecutive words.
- Throughput: with the producer always valid, one word per WIDTH+GAP cycles. data_ready rises in the cycle after each load, which leaves WIDTH+GAP-1 cycles to refill the holding register.
- Producer stall: if data_valid is low when the gap ends, the block returns to IDLE. serial_bit stays 0 until the next word is loaded.
- data_in is sampled only at an accept edge; it may change freely otherwise.

## Structure
- Shared package: state enum {IDLE, SHIFT, GAP} and the counter-width helper function.
- One natural sub-module, bit_serializer_hold: the holding register with its valid/ready logic. The FSM, counters and shifter stay in the top module.
- Expected size: roughly 150–250 lines of RTL.

## Test plan
- Single word, WIDTH=8, GAP=1, MSB_FIRST=1, data_in=8'b0110_1111 accepted at edge 0
  - Edges 1–8: serial_bit = 0,1,1,0,1,1,1,1 with serial_active=1; word_start=1 only after edge 1.
  - Edge 9: serial_bit=0; then IDLE.
- Back-to-back, GAP=0, words 8'hFF then 8'h00 with data_valid held high
  - 16 consecutive serial_active cycles: eight 1s then eight 0s.
  - word_start pulses at cycles 1 and 9.
  - data_ready returns high in the cycle after each load.
- Gap insertion, GAP=3, two words 8'hFF
  - Output: eight 1s, then exactly three cycles of 0 with serial_active=0, then eight 1s.
- LSB-first, MSB_FIRST=0, data_in=8'b0000_0011
  - Output sequence: 1,1,0,0,0,0,0,0.
- Backpressure: hold a second word with data_valid high while data_ready=0 during the shift
  - No accept until data_ready=1.
  - data_in changes while not ready are ignored.
  - The accepted value is the one present at the accept edge.
- Reset mid-word: assert reset low during bit 4 of 8'hAA
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - data_ready reads 1.
  - After release, the next accepted word 8'h0F serializes cleanly with word_start=1.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared FSM state type and counter sizing helper for the bit serializer.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-word holding register with valid/ready handshake feeding the serializer.
module bit_serializer_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             unload,
    output logic             data_ready,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);
    logic [WIDTH-1:0] data_r;
    logic             full_r;
    logic             accept_s;

    assign accept_s   = data_valid && !full_r;
    assign data_ready = !full_r;
    assign hold_data  = data_r;
    assign hold_full  = full_r;

    // Capture on accept; unload is only requested while full, so the two never coincide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_r <= {WIDTH{1'b0}};
            full_r <= 1'b0;
        end else if (accept_s) begin
            data_r <= data_in;
            full_r <= 1'b1;
        end else if (unload) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with forced-zero gaps between words and a
// one-word holding register for continuous streaming.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_bit,
    output logic             serial_active,
    output logic             word_start
);
    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

    state_t           state_r, state_n;
    logic [WIDTH-1:0] shift_r, shift_n;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_n;
    logic [GW-1:0]    gap_cnt_r, gap_cnt_n;
    logic             bit_r, bit_n;
    logic             active_r, active_n;
    logic             start_r, start_n;
    logic             load_s;
    logic             hold_full_s;
    logic [WIDTH-1:0] hold_data_s;

    bit_serializer_hold #(.WIDTH(WIDTH)) u_hold (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .unload     (load_s),
        .data_ready (data_ready),
        .hold_data  (hold_data_s),
        .hold_full  (hold_full_s)
    );

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // Next-state logic; the shifter holds the bits still to come, and the
    // bit being presented is already in the output register.
    always_comb begin
        state_n   = state_r;
        shift_n   = shift_r;
        bit_cnt_n = bit_cnt_r;
        gap_cnt_n = gap_cnt_r;
        bit_n     = 1'b0;
        active_n  = 1'b0;
        start_n   = 1'b0;
        load_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (hold_full_s) begin
                    load_s = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_r == BIT_LAST) begin
                    if (GAP > 0) begin
                        state_n   = S_GAP;
                        gap_cnt_n = {GW{1'b0}};
                    end else if (hold_full_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    bit_n     = head_bit(shift_r);
                    active_n  = 1'b1;
                    shift_n   = advance(shift_r);
                    bit_cnt_n = bit_cnt_r + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    if (hold_full_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt_r + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (load_s) begin
            state_n   = S_SHIFT;
            shift_n   = advance(hold_data_s);
            bit_cnt_n = {BW{1'b0}};
            bit_n     = head_bit(hold_data_s);
            active_n  = 1'b1;
            start_n   = 1'b1;
        end else begin
            start_n = 1'b0;
        end
    end

    // State, shifter, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            gap_cnt_r <= {GW{1'b0}};
            bit_r     <= 1'b0;
            active_r  <= 1'b0;
            start_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            shift_r   <= shift_n;
            bit_cnt_r <= bit_cnt_n;
            gap_cnt_r <= gap_cnt_n;
            bit_r     <= bit_n;
            active_r  <= active_n;
            start_r   <= start_n;
        end
    end

    assign serial_bit    = bit_r;
    assign serial_active = active_r;
    assign word_start    = start_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: four serializer configurations, table-driven vectors,
// hand-written multi-cycle sequences and a per-instance bit-stream scoreboard.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din [4];
    logic [3:0] dv;
    wire  [3:0] dr;
    wire  [3:0] sb;
    wire  [3:0] sa;
    wire  [3:0] ws;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_q [4][$];
    logic [1:0] e;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [7:0] bits;
    } vec_t;
    vec_t vecs [6];

    int          vi;
    int          n_got;
    logic [23:0] got_bits;

    always #5 clk = ~clk;

    // idx 0: GAP=1 MSB-first, 1: GAP=0, 2: GAP=3, 3: GAP=1 LSB-first
    bit_serializer #(.WIDTH(8), .GAP(1), .MSB_FIRST(1)) u_g1 (
        .clock(clk), .reset(rst_n), .data_in(din[0]), .data_valid(dv[0]), .data_ready(dr[0]),
        .serial_bit(sb[0]), .serial_active(sa[0]), .word_start(ws[0]));
    bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u_g0 (
        .clock(clk), .reset(rst_n), .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]),
        .serial_bit(sb[1]), .serial_active(sa[1]), .word_start(ws[1]));
    bit_serializer #(.WIDTH(8), .GAP(3), .MSB_FIRST(1)) u_g3 (
        .clock(clk), .reset(rst_n), .data_in(din[2]), .data_valid(dv[2]), .data_ready(dr[2]),
        .serial_bit(sb[2]), .serial_active(sa[2]), .word_start(ws[2]));
    bit_serializer #(.WIDTH(8), .GAP(1), .MSB_FIRST(0)) u_lsb (
        .clock(clk), .reset(rst_n), .data_in(din[3]), .data_valid(dv[3]), .data_ready(dr[3]),
        .serial_bit(sb[3]), .serial_active(sa[3]), .word_start(ws[3]));

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", name, idx, got, exp, $time);
        end
    endtask

    // Present a word from a negedge, hold it until ready, release after the accept edge.
    task automatic send(input int i, input logic [7:0] d);
        int t;
        t = 0;
        din[i] = d;
        dv[i]  = 1'b1;
        while (dr[i] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_timeout", i, (t < 200) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        dv[i] = 1'b0;
    endtask

    // Scoreboard push: expected {word_start, bit} stream of every accepted word.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n && dv[i] && dr[i]) begin
                for (int b = 0; b < 8; b++) begin
                    exp_q[i].push_back({(b == 0) ? 1'b1 : 1'b0,
                                        (i == 3) ? din[i][b] : din[i][7 - b]});
                end
            end
        end
    end

    // Scoreboard pop: compare each active bit, and require zeros when inactive.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                exp_q[i].delete();
            end else if (sa[i]) begin
                check("sb_queue_nonempty", i, (exp_q[i].size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    check("sb_bit", i, sb[i], e[0]);
                    check("sb_word_start", i, ws[i], e[1]);
                end
            end else begin
                check("idle_serial_bit", i, sb[i], 32'd0);
                check("idle_word_start", i, ws[i], 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        dv    = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("reset_ready", i, dr[i], 32'd1);
            check("reset_active", i, sa[i], 32'd0);
            check("reset_bit", i, sb[i], 32'd0);
            check("reset_start", i, ws[i], 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single words: bits[7] is the first bit on the wire.
        vecs[0] = '{0, 8'b0110_1111, 8'b0110_1111};
        vecs[1] = '{0, 8'hA5,        8'hA5};
        vecs[2] = '{3, 8'b0000_0011, 8'b1100_0000};
        vecs[3] = '{3, 8'b1011_0001, 8'b1000_1101};
        vecs[4] = '{1, 8'h3C,        8'h3C};
        vecs[5] = '{2, 8'hC5,        8'hC5};
        for (int v = 0; v < 6; v++) begin
            vi = vecs[v].inst;
            send(vi, vecs[v].data);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check("vec_active", v, sa[vi], 32'd1);
                check("vec_bit", v, sb[vi], vecs[v].bits[7 - k]);
                check("vec_start", v, ws[vi], (k == 0) ? 32'd1 : 32'd0);
            end
            @(negedge clk);
            check("vec_end_active", v, sa[vi], 32'd0);
            check("vec_end_bit", v, sb[vi], 32'd0);
            repeat (5) @(negedge clk);
        end

        // GAP=0 back-to-back: FF then 00 with valid held high.
        din[1] = 8'hFF;
        dv[1]  = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check("b2b_active", c, sa[1], (c >= 2 && c <= 17));
            check("b2b_bit", c, sb[1], (c >= 2 && c <= 9));
            check("b2b_start", c, ws[1], (c == 2 || c == 10));
            check("b2b_ready", c, dr[1], (c == 2 || c >= 10));
            if (c == 1) din[1] = 8'h00;
            if (c == 3) dv[1] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // GAP=3: two FF words separated by exactly three idle zeros.
        din[2] = 8'hFF;
        dv[2]  = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            check("gap_active", c, sa[2], ((c >= 2 && c <= 9) || (c >= 13 && c <= 20)));
            check("gap_bit", c, sb[2], ((c >= 2 && c <= 9) || (c >= 13 && c <= 20)));
            check("gap_start", c, ws[2], (c == 2 || c == 13));
            check("gap_ready", c, dr[2], (c == 2 || c >= 13));
            if (c == 3) dv[2] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Backpressure: third word waits, data_in churns until the accept edge.
        got_bits = 24'h000000;
        n_got    = 0;
        din[0]   = 8'hC3;
        dv[0]    = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (sa[0]) begin
                got_bits = {got_bits[22:0], sb[0]};
                n_got++;
            end
            if (c <= 11) check("bp_ready", c, dr[0], (c == 2 || c == 11));
            if (c == 1) din[0] = 8'h5A;
            else if (c >= 3 && c <= 10) din[0] = 8'h10 + 8'(c);
            else if (c == 11) din[0] = 8'h96;
            else if (c == 12) begin
                dv[0]  = 1'b0;
                din[0] = 8'hFF;
            end
        end
        check("bp_bit_count", 0, n_got, 32'd24);
        check("bp_stream", 0, {8'h00, got_bits}, 32'h00C35A96);
        repeat (3) @(negedge clk);

        // Reset mid-word while bit 4 of AA is on the wire.
        send(0, 8'hAA);
        repeat (5) @(negedge clk);
        check("rst_pre_active", 0, sa[0], 32'd1);
        check("rst_pre_bit", 0, sb[0], 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_active", 0, sa[0], 32'd0);
        check("rst_async_bit", 0, sb[0], 32'd0);
        check("rst_async_start", 0, ws[0], 32'd0);
        check("rst_async_ready", 0, dr[0], 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_resume", c, sa[0], 32'd0);
        end
        send(0, 8'h0F);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_after_active", k, sa[0], 32'd1);
            check("rst_after_bit", k, sb[0], (k >= 4) ? 32'd1 : 32'd0);
            check("rst_after_start", k, ws[0], (k == 0) ? 32'd1 : 32'd0);
        end

        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) check("sb_drained", i, exp_q[i].size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
